// File: rtl/xulie_gen.sv
// rtl/xulie_gen.sv - serial pattern transmitter, MSB-first, single-shot or repeated frames
module xulie_gen #(
  parameter int       WIDTH    = 8,
  parameter int       LEN_W    = 4,
  parameter int       GAP_CYC  = 2,
  parameter bit       IDLE_LVL = 1'b1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] Pattern,
  input  logic [LEN_W-1:0] Len,
  input  logic             Repeat,
  input  logic             Stop,
  output logic             Dout,
  output logic             Dvalid,
  output logic             Busy,
  output logic             Done
);

  // Gap counter holds GAP_CYC-1 down to 0; keep at least one bit when there is no gap.
  localparam int GW = (GAP_CYC < 2) ? 1 : $clog2(GAP_CYC + 1);

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(WIDTH);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
  localparam logic [GW-1:0]    GAP_ONE = GW'(1);
  localparam logic [GW-1:0]    GAP_LD  = GW'(GAP_CYC - 1);

  typedef enum logic [3:0] {
    IDLE = 4'b0001,
    SEND = 4'b0010,
    GAP  = 4'b0100,
    FIN  = 4'b1000
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shift_reg, shift_nxt;
  logic [LEN_W-1:0] cnt, cnt_nxt;
  logic [LEN_W-1:0] len_reg, len_nxt;
  logic             rep_reg, rep_nxt;
  logic             stop_pend, stop_nxt;
  logic [GW-1:0]    gap_cnt, gap_nxt;

  logic [LEN_W-1:0] len_clamp;
  logic             eff_stop;
  logic [WIDTH-1:0] shifted_nxt;
  logic             dout_nxt;

  // Clamp the requested length: 0 or anything past WIDTH means a full-width frame.
  always_comb begin
    len_clamp = Len;
    if (Len == '0 || Len > LEN_MAX) begin
      len_clamp = LEN_MAX;
    end
  end

  // Next-state and datapath decisions; a Stop seen this cycle counts as already pending.
  always_comb begin
    state_nxt = state;
    shift_nxt = shift_reg;
    cnt_nxt   = cnt;
    len_nxt   = len_reg;
    rep_nxt   = rep_reg;
    stop_nxt  = stop_pend;
    gap_nxt   = gap_cnt;
    eff_stop  = stop_pend | Stop;

    case (state)
      IDLE: begin
        stop_nxt = 1'b0;
        if (Start) begin
          shift_nxt = Pattern;
          len_nxt   = len_clamp;
          rep_nxt   = Repeat;
          cnt_nxt   = len_clamp - LEN_ONE;
          stop_nxt  = Stop;
          state_nxt = SEND;
        end
      end
      SEND: begin
        stop_nxt = eff_stop;
        if (cnt == '0) begin
          if (rep_reg && !eff_stop) begin
            if (GAP_CYC > 0) begin
              gap_nxt   = GAP_LD;
              state_nxt = GAP;
            end else begin
              cnt_nxt = len_reg - LEN_ONE;
            end
          end else begin
            state_nxt = FIN;
          end
        end else begin
          cnt_nxt = cnt - LEN_ONE;
        end
      end
      GAP: begin
        stop_nxt = eff_stop;
        if (gap_cnt == '0) begin
          if (eff_stop) begin
            state_nxt = FIN;
          end else begin
            cnt_nxt   = len_reg - LEN_ONE;
            state_nxt = SEND;
          end
        end else begin
          gap_nxt = gap_cnt - GAP_ONE;
        end
      end
      FIN: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Bit to present next cycle: selected by the next counter value out of the next shift register.
  always_comb begin
    shifted_nxt = shift_nxt >> cnt_nxt;
    dout_nxt    = (state_nxt == SEND) ? shifted_nxt[0] : IDLE_LVL;
  end

  // State, datapath and registered outputs; reset wins over everything, even mid-frame.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      shift_reg <= '0;
      cnt       <= '0;
      len_reg   <= '0;
      rep_reg   <= 1'b0;
      stop_pend <= 1'b0;
      gap_cnt   <= '0;
      Dout      <= IDLE_LVL;
      Dvalid    <= 1'b0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      shift_reg <= shift_nxt;
      cnt       <= cnt_nxt;
      len_reg   <= len_nxt;
      rep_reg   <= rep_nxt;
      stop_pend <= stop_nxt;
      gap_cnt   <= gap_nxt;
      Dout      <= dout_nxt;
      Dvalid    <= (state_nxt == SEND);
      Busy      <= (state_nxt != IDLE);
      Done      <= (state_nxt == FIN);
    end
  end

endmodule
